// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the MIPS-lite datapath.
// The controller uses the master modport; the datapath side uses slave.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       rs_neg;
  logic       n_flag;

  logic       pcwrite;
  logic       pcwritecond;
  logic       irwrite;
  logic       regwrite;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdest;
  logic       alusrca;
  logic       link;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       instr_done;
  logic [1:0] fault;

  modport master (
    input  opcode, mem_ready, rs_neg, n_flag,
    output pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite,
           iord, memtoreg, regdest, alusrca, link, alusrcb, aluop, pcsource,
           state, instr_done, fault
  );

  modport slave (
    output opcode, mem_ready, rs_neg, n_flag,
    input  pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite,
           iord, memtoreg, regdest, alusrca, link, alusrcb, aluop, pcsource,
           state, instr_done, fault
  );
endinterface

// File: rtl/multicycle_control.sv
// 16-state Moore control FSM for the MIPS-lite multicycle datapath, with a
// memory-ready wait counter and a sticky fault code (illegal opcode / timeout).
module multicycle_control #(
  parameter logic [5:0]  OP_LW     = 6'd35,
  parameter logic [5:0]  OP_SW     = 6'd43,
  parameter logic [5:0]  OP_BEQ    = 6'd4,
  parameter logic [5:0]  OP_J      = 6'd2,
  parameter logic [5:0]  OP_ORI    = 6'd13,
  parameter logic [5:0]  OP_BLTZAL = 6'd34,
  parameter logic [5:0]  OP_JSPAL  = 6'd19,
  parameter logic [5:0]  OP_BALN   = 6'd27,
  parameter int unsigned WAIT_MAX  = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_WB_MEM = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_WB_ALU = 4'd7,
    S_BEQ    = 4'd8,  S_JUMP   = 4'd9,  S_ORI_EX = 4'd10, S_ORI_WB = 4'd11,
    S_BLTZAL = 4'd12, S_JSPAL  = 4'd13, S_BALN   = 4'd14, S_FAULT  = 4'd15
  } state_t;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_next;
  logic [1:0]    fault_q, fault_next;
  logic          timed_out, mem_state;

  logic pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite;
  logic iord, memtoreg, regdest, alusrca, link, instr_done;
  logic [1:0] alusrcb, aluop, pcsource;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= F_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      fault_q  <= fault_next;
    end
  end

  assign timed_out = (WAIT_MAX != 0) && (wait_cnt == CW'(WAIT_MAX));
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) ||
                     (state == S_MEMWR) || (state == S_JSPAL);

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    fault_next  = fault_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdest     = 1'b0;
    alusrca     = 1'b0;
    link        = 1'b0;
    instr_done  = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;

    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (bus.mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_FAULT;
          fault_next = F_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.opcode)
          6'd0:         state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JUMP;
          OP_ORI:       state_next = S_ORI_EX;
          OP_BLTZAL:    state_next = S_BLTZAL;
          OP_JSPAL:     state_next = S_JSPAL;
          OP_BALN:      state_next = S_BALN;
          default: begin
            state_next = S_FAULT;
            fault_next = F_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_WB_MEM;
        end else if (timed_out) begin
          state_next = S_FAULT;
          fault_next = F_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_FAULT;
          fault_next = F_TIMEOUT;
        end
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        regwrite   = 1'b1;
        regdest    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_ORI_EX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = 2'b11;
        state_next = S_ORI_WB;
      end
      S_ORI_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BLTZAL: begin
        link       = 1'b1;
        pcsource   = 2'b01;
        regwrite   = bus.rs_neg;
        pcwrite    = bus.rs_neg;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JSPAL: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        link     = 1'b1;
        if (bus.mem_ready) begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_FAULT;
          fault_next = F_TIMEOUT;
        end
      end
      S_BALN: begin
        link       = 1'b1;
        pcsource   = 2'b10;
        regwrite   = bus.n_flag;
        pcwrite    = bus.n_flag;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: ;
      default: ;
    endcase

    // Counter restarts whenever a state is entered; only stalls advance it.
    if (state_next != state) begin
      wait_next = '0;
    end else if (mem_state && !bus.mem_ready) begin
      wait_next = wait_cnt + CW'(1);
    end else begin
      wait_next = wait_cnt;
    end
  end

  // Architectural write enables are suppressed while reset is asserted.
  assign bus.pcwrite     = pcwrite     & ~reset;
  assign bus.pcwritecond = pcwritecond & ~reset;
  assign bus.irwrite     = irwrite     & ~reset;
  assign bus.regwrite    = regwrite    & ~reset;
  assign bus.memwrite    = memwrite    & ~reset;
  assign bus.memread     = memread;
  assign bus.iord        = iord;
  assign bus.memtoreg    = memtoreg;
  assign bus.regdest     = regdest;
  assign bus.alusrca     = alusrca;
  assign bus.link        = link;
  assign bus.alusrcb     = alusrcb;
  assign bus.aluop       = aluop;
  assign bus.pcsource    = pcsource;
  assign bus.instr_done  = instr_done;
  assign bus.state       = state;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: a table of per-cycle inputs and
// hand-derived outputs, plus timeout sequences on a WAIT_MAX=3 instance.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_if b0 ();
  multicycle_control_if b3 ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.master)
  );

  multicycle_control #(.WAIT_MAX(3)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (b3.master)
  );

  // Control bundle: {pcwrite,pcwritecond,irwrite,regwrite,memread,memwrite,
  //                  iord,memtoreg,regdest,alusrca,link, alusrcb, aluop,
  //                  pcsource, instr_done, fault}
  logic [19:0] act0, act3;
  assign act0 = {b0.pcwrite, b0.pcwritecond, b0.irwrite, b0.regwrite, b0.memread,
                 b0.memwrite, b0.iord, b0.memtoreg, b0.regdest, b0.alusrca, b0.link,
                 b0.alusrcb, b0.aluop, b0.pcsource, b0.instr_done, b0.fault};
  assign act3 = {b3.pcwrite, b3.pcwritecond, b3.irwrite, b3.regwrite, b3.memread,
                 b3.memwrite, b3.iord, b3.memtoreg, b3.regdest, b3.alusrca, b3.link,
                 b3.alusrcb, b3.aluop, b3.pcsource, b3.instr_done, b3.fault};

  localparam logic [19:0] C_FETCH_RDY = 20'b101010_00000_01_00_00_0_00;
  localparam logic [19:0] C_FETCH_NR  = 20'b000010_00000_01_00_00_0_00;
  localparam logic [19:0] C_DECODE    = 20'b000000_00000_11_00_00_0_00;
  localparam logic [19:0] C_MEMADR    = 20'b000000_00010_10_00_00_0_00;
  localparam logic [19:0] C_MEMRD     = 20'b000010_10000_00_00_00_0_00;
  localparam logic [19:0] C_WB_MEM    = 20'b000100_01000_00_00_00_1_00;
  localparam logic [19:0] C_MEMWR_RDY = 20'b000001_10000_00_00_00_1_00;
  localparam logic [19:0] C_MEMWR_NR  = 20'b000001_10000_00_00_00_0_00;
  localparam logic [19:0] C_EXEC      = 20'b000000_00010_00_10_00_0_00;
  localparam logic [19:0] C_WB_ALU    = 20'b000100_00100_00_00_00_1_00;
  localparam logic [19:0] C_BEQ       = 20'b010000_00010_00_01_01_1_00;
  localparam logic [19:0] C_JUMP      = 20'b100000_00000_00_00_10_1_00;
  localparam logic [19:0] C_ORI_EX    = 20'b000000_00010_10_11_00_0_00;
  localparam logic [19:0] C_ORI_WB    = 20'b000100_00000_00_00_00_1_00;
  localparam logic [19:0] C_BLTZ_NT   = 20'b000000_00001_00_00_01_1_00;
  localparam logic [19:0] C_BLTZ_T    = 20'b100100_00001_00_00_01_1_00;
  localparam logic [19:0] C_JSPAL_RDY = 20'b100001_10001_00_00_10_1_00;
  localparam logic [19:0] C_JSPAL_NR  = 20'b000001_10001_00_00_00_0_00;
  localparam logic [19:0] C_BALN_NT   = 20'b000000_00001_00_00_10_1_00;
  localparam logic [19:0] C_BALN_T    = 20'b100100_00001_00_00_10_1_00;
  localparam logic [19:0] C_FAULT_ILL = 20'b000000_00000_00_00_00_0_01;
  localparam logic [19:0] C_FAULT_TO  = 20'b000000_00000_00_00_00_0_10;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic       rsn;
    logic       nf;
    logic [3:0] st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic rsn, input logic nf, input logic [3:0] st,
                     input logic [19:0] ctl);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.rsn = rsn; v.nf = nf; v.st = st; v.ctl = ctl;
    vq.push_back(v);
  endtask

  initial begin
    // Reset held for two sampled cycles; enables forced low in FETCH.
    add(1, 6'd0,  1, 0, 0, 4'd0,  C_FETCH_NR);
    add(1, 6'd0,  1, 0, 0, 4'd0,  C_FETCH_NR);
    // lw, no waits: 5 cycles
    add(0, 6'd35, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd35, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd35, 1, 0, 0, 4'd2,  C_MEMADR);
    add(0, 6'd35, 1, 0, 0, 4'd3,  C_MEMRD);
    add(0, 6'd35, 1, 0, 0, 4'd4,  C_WB_MEM);
    // sw with two not-ready cycles in MEMWR: 6 cycles
    add(0, 6'd43, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd43, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd43, 1, 0, 0, 4'd2,  C_MEMADR);
    add(0, 6'd43, 0, 0, 0, 4'd5,  C_MEMWR_NR);
    add(0, 6'd43, 0, 0, 0, 4'd5,  C_MEMWR_NR);
    add(0, 6'd43, 1, 0, 0, 4'd5,  C_MEMWR_RDY);
    // R-type
    add(0, 6'd0,  1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd0,  1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd0,  1, 0, 0, 4'd6,  C_EXEC);
    add(0, 6'd0,  1, 0, 0, 4'd7,  C_WB_ALU);
    // beq, j
    add(0, 6'd4,  1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd4,  1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd4,  1, 0, 0, 4'd8,  C_BEQ);
    add(0, 6'd2,  1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd2,  1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd2,  1, 0, 0, 4'd9,  C_JUMP);
    // bltzal not taken, then taken
    add(0, 6'd34, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd34, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd34, 1, 0, 0, 4'd12, C_BLTZ_NT);
    add(0, 6'd34, 1, 1, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd34, 1, 1, 0, 4'd1,  C_DECODE);
    add(0, 6'd34, 1, 1, 0, 4'd12, C_BLTZ_T);
    // jspal with one memory wait
    add(0, 6'd19, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd19, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd19, 0, 0, 0, 4'd13, C_JSPAL_NR);
    add(0, 6'd19, 1, 0, 0, 4'd13, C_JSPAL_RDY);
    // baln not taken, then taken
    add(0, 6'd27, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd27, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd27, 1, 0, 0, 4'd14, C_BALN_NT);
    add(0, 6'd27, 1, 0, 1, 4'd0,  C_FETCH_RDY);
    add(0, 6'd27, 1, 0, 1, 4'd1,  C_DECODE);
    add(0, 6'd27, 1, 0, 1, 4'd14, C_BALN_T);
    // ori, then ori abandoned by reset in ORI_EX
    add(0, 6'd13, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd13, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd13, 1, 0, 0, 4'd10, C_ORI_EX);
    add(0, 6'd13, 1, 0, 0, 4'd11, C_ORI_WB);
    add(0, 6'd13, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd13, 1, 0, 0, 4'd1,  C_DECODE);
    add(1, 6'd13, 1, 0, 0, 4'd10, C_ORI_EX);
    add(0, 6'd13, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd13, 1, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd13, 1, 0, 0, 4'd10, C_ORI_EX);
    add(0, 6'd13, 1, 0, 0, 4'd11, C_ORI_WB);
    // lw with a FETCH wait and a MEMRD wait; mem_ready low in non-memory states
    add(0, 6'd35, 0, 0, 0, 4'd0,  C_FETCH_NR);
    add(0, 6'd35, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd35, 0, 0, 0, 4'd1,  C_DECODE);
    add(0, 6'd35, 0, 0, 0, 4'd2,  C_MEMADR);
    add(0, 6'd35, 0, 0, 0, 4'd3,  C_MEMRD);
    add(0, 6'd35, 1, 0, 0, 4'd3,  C_MEMRD);
    add(0, 6'd35, 1, 0, 0, 4'd4,  C_WB_MEM);
    // illegal opcode: sticky FAULT for 10 cycles, then reset clears it
    add(0, 6'd63, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd63, 1, 0, 0, 4'd1,  C_DECODE);
    for (int k = 0; k < 10; k++)
      add(0, 6'd63, logic'(k % 2), 1, 1, 4'd15, C_FAULT_ILL);
    add(1, 6'd63, 1, 0, 0, 4'd15, C_FAULT_ILL);
    add(0, 6'd63, 1, 0, 0, 4'd0,  C_FETCH_RDY);
    add(0, 6'd63, 1, 0, 0, 4'd1,  C_DECODE);

    b0.opcode = 6'd0; b0.mem_ready = 1'b1; b0.rs_neg = 1'b0; b0.n_flag = 1'b0;
    b3.opcode = 6'd0; b3.mem_ready = 1'b0; b3.rs_neg = 1'b0; b3.n_flag = 1'b0;
    reset = 1'b1;
    reset3 = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      reset        = vq[i].rst;
      b0.opcode    = vq[i].op;
      b0.mem_ready = vq[i].rdy;
      b0.rs_neg    = vq[i].rsn;
      b0.n_flag    = vq[i].nf;
      @(negedge clk);
      check($sformatf("v%0d state", i), 32'(b0.state), 32'(vq[i].st));
      check($sformatf("v%0d ctrl", i), 32'(act0), 32'(vq[i].ctl));
      @(posedge clk); #1;
    end

    // WAIT_MAX=3: four not-ready FETCH cycles, then timeout fault.
    reset3 = 1'b1; b3.mem_ready = 1'b0;
    @(posedge clk); #1;
    reset3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("to fetch%0d state", c), 32'(b3.state), 32'd0);
      check($sformatf("to fetch%0d ctrl", c), 32'(act3), 32'(C_FETCH_NR));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to fault state", 32'(b3.state), 32'd15);
    check("to fault ctrl", 32'(act3), 32'(C_FAULT_TO));
    @(posedge clk); #1;
    @(negedge clk);
    check("to fault hold", 32'(act3), 32'(C_FAULT_TO));

    // WAIT_MAX=3: ready arriving in the fourth cycle still completes.
    @(posedge clk); #1;
    reset3 = 1'b1;
    @(posedge clk); #1;
    reset3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("late fetch%0d state", c), 32'(b3.state), 32'd0);
      @(posedge clk); #1;
    end
    b3.mem_ready = 1'b1;
    @(negedge clk);
    check("late fetch3 ctrl", 32'(act3), 32'(C_FETCH_RDY));
    @(posedge clk); #1;
    @(negedge clk);
    check("late decode state", 32'(b3.state), 32'd1);
    check("late decode ctrl", 32'(act3), 32'(C_DECODE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS-lite core: a 16-state Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks. It sits beside the shared-memory multicycle datapath. It supports R-type, lw, sw, beq, j, ori, bltzal, jspal and baln, waits on a memory-ready handshake, and latches a fault on an illegal opcode or a memory timeout. Opcodes and the timeout bound are parameters.

## Interface
- OP_LW, 6'd35, lw opcode
- OP_SW, 6'd43, sw opcode
- OP_BEQ, 6'd4, beq opcode
- OP_J, 6'd2, j opcode
- OP_ORI, 6'd13, ori opcode
- OP_BLTZAL, 6'd34, bltzal opcode
- OP_JSPAL, 6'd19, jspal opcode
- OP_BALN, 6'd27, baln opcode
- WAIT_MAX, 15, maximum memory wait cycles tolerated; 0 disables the timeout
- clk  in  1  clock; one clock domain, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the IR
- mem_ready  in  1  memory completes the current access this cycle
- rs_neg  in  1  datapath flag: rs[31] (bltzal condition)
- n_flag  in  1  datapath status N flag (baln condition)
- pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite  out  1 each  enables
- iord, memtoreg, regdest, alusrca, link  out  1 each  mux selects; link selects $31 and PC+4
- alusrcb  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 or-zero-ext
- pcsource  out  2  00 ALU, 01 ALUOut, 10 jump target
- state  out  4  current state code
- instr_done  out  1  high in the last cycle of each instruction
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation
- All outputs not listed for a state are 0. Outputs decode from the state register; conditional enables also use mem_ready, rs_neg or n_flag.
- 0 FETCH: memread, alusrcb=01.
  - If mem_ready: irwrite, pcwrite, go to DECODE. Otherwise stay.
- 1 DECODE: alusrcb=11. Next state by opcode:
  - 0 → EXEC
  - lw/sw → MEMADR
  - beq → BEQ
  - j → JUMP
  - ori → ORI_EX
  - bltzal → BLTZAL
  - jspal → JSPAL
  - baln → BALN
  - anything else → FAULT with fault=01
- 2 MEMADR: alusrca, alusrcb=10. lw → MEMRD; sw → MEMWR.
- 3 MEMRD: memread, iord. mem_ready → WB_MEM.
- 4 WB_MEM: regwrite, memtoreg, instr_done → FETCH.
- 5 MEMWR: memwrite, iord. mem_ready → instr_done, FETCH.
- 6 EXEC: alusrca, aluop=10 → WB_ALU.
- 7 WB_ALU: regwrite, regdest, instr_done → FETCH.
- 8 BEQ: alusrca, aluop=01, pcwritecond, pcsource=01, instr_done → FETCH.
- 9 JUMP: pcwrite, pcsource=10, instr_done → FETCH.
- 10 ORI_EX: alusrca, alusrcb=10, aluop=11 → ORI_WB.
- 11 ORI_WB: regwrite (regdest=0, rt), instr_done → FETCH.
- 12 BLTZAL: link, pcsource=01.
  - If rs_neg: regwrite, pcwrite.
  - Always instr_done → FETCH.
- 13 JSPAL: memwrite, iord, link (stores PC+4 at the $sp address). mem_ready → pcwrite, pcsource=10, instr_done → FETCH.
- 14 BALN: link, pcsource=10.
  - If n_flag: regwrite, pcwrite.
  - Always instr_done → FETCH.
- 15 FAULT: all enables 0; fault holds its value; stays until reset.
- Wait counter, width clog2(WAIT_MAX+1):
  - Cleared on entry to each memory state (FETCH, MEMRD, MEMWR, JSPAL).
  - Increments on each cycle in that state with mem_ready=0.
  - If WAIT_MAX≠0, count==WAIT_MAX and mem_ready=0: next state is FAULT with fault=10.

## Timing
- Reset: on the clk edge with reset=1, state=FETCH, counter=0, fault=00.
- While reset=1, pcwrite, pcwritecond, irwrite, regwrite and memwrite are forced to 0.
- Reset mid-instruction abandons the instruction; the next cycle is FETCH.
- Latency with mem_ready always 1:
  - lw 5 cycles
  - sw, R-type, ori 4 cycles
  - beq, j, bltzal, jspal, baln 3 cycles
- Each memory wait cycle adds 1.
- mem_ready is sampled only in memory states; it is ignored elsewhere.
- Timeout: at most WAIT_MAX not-ready cycles are tolerated; ready on the next cycle still completes normally.
- Register writes occur on the clk edge ending the state.
- instr_done is combinational and valid in that same cycle.

## Test plan
- Reset held 2 cycles, then opcode=35 and mem_ready=1 → states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; instr_done once; 5 cycles.
- opcode=43, mem_ready low for 2 cycles in MEMWR → memwrite=1 for 3 cycles in state 5, then FETCH; total 6 cycles.
- opcode=34, rs_neg=0, then the same with rs_neg=1 → regwrite and pcwrite 0 in the first case; in the second both 1 with link=1 and pcsource=01 in state 12.
- opcode=6'd63 → FAULT with fault=01; enables stay 0 for 10 cycles; reset returns to FETCH with fault=00.
- WAIT_MAX=3, mem_ready=0 in FETCH → stays 4 cycles, then state=15, fault=10. Same with ready in the 4th cycle → DECODE, no fault.
- opcode=13 → states 0,1,10,11; in 10 aluop=11 and alusrcb=10; in 11 regwrite=1 and regdest=0. Reset asserted in state 10 → next state 0 and no regwrite.
